// File: rtl/soundrive_pkg.sv
// soundrive_pkg: shared types and constants for the Soundrive/Covox DAC block
package soundrive_pkg;

   typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;

   localparam logic [7:0] PORT_L0    = 8'h0F;
   localparam logic [7:0] PORT_L1    = 8'h1F;
   localparam logic [7:0] PORT_R0    = 8'h4F;
   localparam logic [7:0] PORT_R1    = 8'h5F;
   localparam logic [7:0] PORT_COVOX = 8'hFB;
   localparam logic [7:0] MID        = 8'h80;

   // One unit step toward tgt; never overshoots, so no wrap-around is possible
   function automatic logic [7:0] step_to(input logic [7:0] v, input logic [7:0] tgt);
      return v < tgt ? v + 8'd1 : v > tgt ? v - 8'd1 : v;
   endfunction

endpackage

// File: rtl/bus_wr_detect.sv
// bus_wr_detect: synchronises the Z80 I/O write strobe into clk28 and emits a one-cycle pulse
module bus_wr_detect (
   input  logic clk28,
   input  logic rst_n,
   input  logic iorq_n,
   input  logic wr_n,
   input  logic m1_n,
   output logic wr_stb
);

   logic [2:0] sync;

   // Two synchroniser stages plus one history stage for edge detection
   always_ff @(posedge clk28 or negedge rst_n)
      if (!rst_n) sync <= '0;
      else        sync <= {sync[1:0], ~iorq_n & ~wr_n & m1_n};

   assign wr_stb = sync[1] & ~sync[2];

endmodule

// File: rtl/soundrive.sv
// soundrive: Soundrive/Covox sample registers with click-free soft start and soft stop
module soundrive
   import soundrive_pkg::*;
#(
   parameter int RAMP_DIV = 256
) (
   input  logic       rst_n,
   input  logic       clk28,
   input  logic       en,
   input  logic       covox_en,
   input  logic [7:0] a,
   input  logic [7:0] d,
   input  logic       iorq_n,
   input  logic       wr_n,
   input  logic       m1_n,
   output logic [7:0] sd_l0,
   output logic [7:0] sd_l1,
   output logic [7:0] sd_r0,
   output logic [7:0] sd_r1
);

   localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;

   state_t        state;
   logic [PW-1:0] presc, presc_inc;
   logic          tick, wr_stb, all_mid, all_zero, cov;
   logic [7:0]    ch [4];
   logic [7:0]    nch [4];
   logic [7:0]    wch [4];
   logic [7:0]    ports [4];

   bus_wr_detect u_wr (
      .clk28  (clk28),
      .rst_n  (rst_n),
      .iorq_n (iorq_n),
      .wr_n   (wr_n),
      .m1_n   (m1_n),
      .wr_stb (wr_stb)
   );

   assign tick      = presc == PW'(RAMP_DIV - 1);
   assign presc_inc = tick ? '0 : presc + 1'b1;
   assign cov       = covox_en && a == PORT_COVOX;
   assign ports     = '{PORT_L0, PORT_L1, PORT_R0, PORT_R1};

   // Ramped channel values for this tick, completion flags, and bus-write results
   always_comb begin
      all_mid  = 1'b1;
      all_zero = 1'b1;
      for (int i = 0; i < 4; i++) begin
         nch[i]   = tick ? step_to(ch[i], state == RAMP_UP ? MID : 8'h00) : ch[i];
         wch[i]   = (wr_stb && (a == ports[i] || cov)) ? d : ch[i];
         all_mid  = all_mid & (nch[i] == MID);
         all_zero = all_zero & (nch[i] == 8'h00);
      end
   end

   // Ramp/enable state machine owning the channel registers and the prescaler
   always_ff @(posedge clk28 or negedge rst_n)
      if (!rst_n) begin
         state <= OFF;
         presc <= '0;
         ch    <= '{default: 8'h00};
      end else begin
         case (state)
            OFF: begin
               presc <= '0;
               ch    <= '{default: 8'h00};
               if (en) state <= RAMP_UP;
            end
            RAMP_UP: begin
               presc <= presc_inc;
               if (!en) state <= RAMP_DOWN;
               else begin
                  ch <= nch;
                  if (all_mid) begin
                     state <= ON;
                     presc <= '0;
                  end
               end
            end
            ON: begin
               presc <= '0;
               if (!en) state <= RAMP_DOWN;
               else     ch <= wch;
            end
            default: begin
               presc <= presc_inc;
               if (en) state <= RAMP_UP;
               else begin
                  ch <= nch;
                  if (all_zero) begin
                     state <= OFF;
                     presc <= '0;
                  end
               end
            end
         endcase
      end

   assign sd_l0 = ch[0];
   assign sd_l1 = ch[1];
   assign sd_r0 = ch[2];
   assign sd_r1 = ch[3];

endmodule

// File: tb/tb_soundrive.sv
// tb_soundrive: scoreboard bench for soundrive with RAMP_DIV = 4
module tb_soundrive;

   typedef struct {
      int          due;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic       rst_n, clk28, en, covox_en, iorq_n, wr_n, m1_n;
   logic [7:0] a, d, sd_l0, sd_l1, sd_r0, sd_r1;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   bit         done = 0;
   exp_t       sb[$];

   soundrive #(.RAMP_DIV(4)) dut (
      .rst_n    (rst_n),
      .clk28    (clk28),
      .en       (en),
      .covox_en (covox_en),
      .a        (a),
      .d        (d),
      .iorq_n   (iorq_n),
      .wr_n     (wr_n),
      .m1_n     (m1_n),
      .sd_l0    (sd_l0),
      .sd_l1    (sd_l1),
      .sd_r0    (sd_r0),
      .sd_r1    (sd_r1)
   );

   initial clk28 = 0;
   always #5 clk28 = ~clk28;

   always @(posedge clk28) cyc <= cyc + 1;

   // Monitor: compares every due expectation on the falling edge, then reports
   always @(negedge clk28) begin : mon
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         n_chk++;
         if ({sd_l0, sd_l1, sd_r0, sd_r1} !== e.val) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc,
                     {sd_l0, sd_l1, sd_r0, sd_r1}, e.val);
         end
      end
      if (done) begin
         if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
         end
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
         $finish;
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic push(input int due, input logic [31:0] v, input string n);
      sb.push_back('{due, v, n});
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk28);
         #1;
      end
   endtask

   task automatic io_write(input logic [7:0] ad, input logic [7:0] dd, input logic m1, input int hold);
      a = ad;
      d = dd;
      m1_n = m1;
      iorq_n = 0;
      wr_n = 0;
      wait_until(cyc + hold);
      iorq_n = 1;
      wr_n = 1;
      m1_n = 1;
      wait_until(cyc + 3);
   endtask

   initial begin
      int t;
      rst_n = 0; en = 1; covox_en = 0; a = 0; d = 0; iorq_n = 1; wr_n = 1; m1_n = 1;
      wait_until(3);
      push(cyc, 32'h00000000, "reset_zero");
      wait_until(cyc + 1);
      // soft start from reset
      rst_n = 1;
      t = cyc;
      push(t + 1,   32'h00000000, "ramp_start");
      push(t + 4,   32'h00000000, "first_step_not_early");
      push(t + 5,   32'h01010101, "first_step");
      push(t + 512, 32'h7F7F7F7F, "ramp_pre_end");
      push(t + 513, 32'h80808080, "ramp_end_on");
      wait_until(t + 520);
      // single write with a long held strobe
      t = cyc;
      push(t + 2,  32'h80808080, "wr_not_early");
      push(t + 3,  32'h803C8080, "wr_l1");
      push(t + 40, 32'h803C8080, "held_strobe_once");
      a = 8'h1F; d = 8'h3C; iorq_n = 0; wr_n = 0;
      wait_until(t + 10);
      d = 8'h55;
      wait_until(t + 40);
      iorq_n = 1; wr_n = 1;
      wait_until(t + 44);
      // covox port
      t = cyc;
      push(t + 6, 32'h803C8080, "covox_disabled");
      io_write(8'hFB, 8'h10, 1, 3);
      covox_en = 1;
      t = cyc;
      push(t + 2, 32'h803C8080, "covox_not_early");
      push(t + 3, 32'h10101010, "covox_all");
      io_write(8'hFB, 8'h10, 1, 3);
      // interrupt acknowledge
      t = cyc;
      push(t + 6, 32'h10101010, "int_ack_ignored");
      io_write(8'h0F, 8'h99, 0, 3);
      t = cyc;
      push(t + 3, 32'h1010F010, "wr_r0");
      io_write(8'h4F, 8'hF0, 1, 3);
      // full soft stop
      en = 0;
      t = cyc;
      push(t + 4,   32'h1010F010, "down_not_early");
      push(t + 5,   32'h0F0FEF0F, "down_first");
      push(t + 24,  32'h0B0BEB0B, "down_write_ignored");
      push(t + 960, 32'h00000100, "down_pre_end");
      push(t + 961, 32'h00000000, "down_end");
      wait_until(t + 20);
      io_write(8'h0F, 8'h77, 1, 3);
      wait_until(t + 965);
      t = cyc;
      push(t + 6,  32'h00000000, "off_write_ignored");
      push(t + 20, 32'h00000000, "off_stays");
      io_write(8'h0F, 8'h55, 1, 3);
      wait_until(t + 21);
      // second soft start
      en = 1;
      t = cyc;
      push(t + 512, 32'h7F7F7F7F, "ramp2_pre_end");
      push(t + 513, 32'h80808080, "ramp2_on");
      wait_until(t + 520);
      t = cyc;
      push(t + 3, 32'h8080F080, "wr_r0_f0");
      io_write(8'h4F, 8'hF0, 1, 3);
      // soft stop reversed into soft start at sd_r0 = 0x70
      en = 0;
      t = cyc;
      push(t + 513,  32'h00007000, "down2_r0_70");
      push(t + 516,  32'h00007000, "reverse_hold");
      push(t + 517,  32'h01017101, "reverse_first_up");
      push(t + 604,  32'h16168016, "up_write_ignored");
      push(t + 1024, 32'h7F7F807F, "up2_pre_end");
      push(t + 1025, 32'h80808080, "up2_on");
      wait_until(t + 514);
      en = 1;
      wait_until(t + 600);
      io_write(8'h1F, 8'h22, 1, 3);
      wait_until(t + 1030);
      t = cyc;
      push(t + 3, 32'hAB808080, "wr_l0_ab");
      io_write(8'h0F, 8'hAB, 1, 3);
      // asynchronous reset in the middle of a ramp
      en = 0;
      t = cyc;
      push(t + 257, 32'h6B404040, "down3_at_40");
      wait_until(t + 258);
      rst_n = 0;
      push(cyc, 32'h00000000, "async_reset");
      wait_until(cyc + 2);
      rst_n = 1;
      t = cyc;
      push(t + 6, 32'h00000000, "after_reset_off");
      io_write(8'h0F, 8'h55, 1, 3);
      for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clk28);
      done = 1;
   end

endmodule
